// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: architectural flag register, condition evaluation,
// fetch redirect and multi-cycle flush. Optional BRANCH_STATS_EN adds
// saturating branch counters.
module branch_resolve_unit #(
  parameter int unsigned FLUSH_DEPTH  = 2,
  parameter logic [15:0] RESET_PC_TGT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flag_we,
  input  logic [2:0]  alu_flags,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [3:0]  br_cond,
  input  logic [15:0] br_target,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        flush,
  output logic [2:0]  flags_q,
  output logic [1:0]  dbg_state
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] stat_total,
  output logic [15:0] stat_taken
`endif
);

  // Handshake: a branch transfers on a rising edge where br_valid && br_ready;
  // br_valid stays high until then, and br_ready is high only in IDLE.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REDIR = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] pc_q, pc_d;
  logic [2:0]  eff_flags;
  logic        accept;
  logic        cond_hit;

  function automatic logic eval_cond(input logic [3:0] cond, input logic [2:0] f);
    logic nf, zf, cf;
    nf = f[2];
    zf = f[1];
    cf = f[0];
    case (cond)
      4'd1:    eval_cond = 1'b1;
      4'd2:    eval_cond = zf;
      4'd3:    eval_cond = !zf;
      4'd4:    eval_cond = nf;
      4'd5:    eval_cond = !nf;
      4'd6:    eval_cond = cf;
      4'd7:    eval_cond = !cf;
      4'd8:    eval_cond = !cf && !zf;
      4'd9:    eval_cond = cf || zf;
      4'd10:   eval_cond = !nf && !zf;
      4'd11:   eval_cond = nf || zf;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  assign br_ready       = (state_q == IDLE);
  assign flush          = (state_q != IDLE);
  assign redirect_valid = (state_q == REDIR);
  assign redirect_pc    = pc_q;
  assign dbg_state      = state_q;

  // Same-cycle flag producer is bypassed so a dependent branch needs no stall.
  assign eff_flags = flag_we ? alu_flags : flags_q;
  assign accept    = br_valid && br_ready;
  assign cond_hit  = eval_cond(br_cond, eff_flags);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (accept && cond_hit) begin
          pc_d    = br_target;
          cnt_d   = 3'(FLUSH_DEPTH - 1);
          state_d = REDIR;
        end
      end
      REDIR, FLUSH: begin
        // cnt_q counts flush cycles still owed after the current one.
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          state_d = FLUSH;
          cnt_d   = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      pc_q    <= RESET_PC_TGT;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      if (flag_we && !flush) flags_q <= alu_flags;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_total <= 16'h0000;
      stat_taken <= 16'h0000;
    end else if (accept) begin
      if (stat_total != 16'hFFFF) stat_total <= stat_total + 16'h0001;
      if (cond_hit && stat_taken != 16'hFFFF) stat_taken <= stat_taken + 16'h0001;
    end
  end
`endif

endmodule
